// File: rtl/alu_pkg.sv
// Shared widths, opcode encodings and shifter mode codes for the 32-bit execute-stage ALU.
package alu_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OP_W    = 4;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_MUL  = 4'b0010;
    localparam logic [OP_W-1:0] ALU_AND  = 4'b0011;
    localparam logic [OP_W-1:0] ALU_OR   = 4'b0100;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'b0101;
    localparam logic [OP_W-1:0] ALU_NOR  = 4'b0110;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'b0111;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'b1000;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'b1001;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'b1010;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'b1011;
    localparam logic [OP_W-1:0] ALU_ROTR = 4'b1100;
    localparam logic [OP_W-1:0] ALU_LUI  = 4'b1101;

    localparam logic [1:0] SH_SLL  = 2'd0;
    localparam logic [1:0] SH_SRL  = 2'd1;
    localparam logic [1:0] SH_SRA  = 2'd2;
    localparam logic [1:0] SH_ROTR = 2'd3;

endpackage

// File: rtl/alu_32bit_if.sv
// Operand/opcode/result bundle between the execute-stage issuer (master) and the ALU (slave).
interface alu_32bit_if;
    import alu_pkg::*;

    logic [OP_W-1:0]  ALUControl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;

    modport master (output ALUControl, A, B, input ALUResult, Zero);
    modport slave  (input ALUControl, A, B, output ALUResult, Zero);

endinterface

// File: rtl/alu_32bit_shifter.sv
// Barrel shifter for SLL/SRL/SRA/ROTR of the data operand by a 5-bit amount; purely combinational.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [1:0]         mode,
    input  logic [SHAMT_W-1:0] amt,
    input  logic [WIDTH-1:0]   data,
    output logic [WIDTH-1:0]   result_c
);

    logic [2*WIDTH-1:0] rot_wide;

    // Rotate via a doubled word so a zero amount needs no special case.
    always_comb begin
        result_c = '0;
        rot_wide = {data, data} >> amt;
        case (mode)
            SH_SLL:  result_c = data << amt;
            SH_SRL:  result_c = data >> amt;
            SH_SRA:  result_c = WIDTH'($signed(data) >>> amt);
            SH_ROTR: result_c = rot_wide[WIDTH-1:0];
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_32bit.sv
// 32-bit execute-stage ALU with registered result and Zero flag (one cycle latency).
// Define ALU_MUL_EN to build the combinational multiplier for opcode 0010; otherwise 0010 returns 0.
module alu_32bit
    import alu_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    alu_32bit_if.slave  bus
);

    logic [1:0]       shift_mode;
    logic [WIDTH-1:0] shift_result_c;
    logic [WIDTH-1:0] next_result;

    // Shifter mode decode kept apart from the result mux to avoid a combinational block loop.
    always_comb begin
        shift_mode = SH_SLL;
        case (bus.ALUControl)
            ALU_SRL:  shift_mode = SH_SRL;
            ALU_SRA:  shift_mode = SH_SRA;
            ALU_ROTR: shift_mode = SH_ROTR;
            default:  shift_mode = SH_SLL;
        endcase
    end

    alu_shifter u_shifter (
        .mode     (shift_mode),
        .amt      (bus.A[SHAMT_W-1:0]),
        .data     (bus.B),
        .result_c (shift_result_c)
    );

    always_comb begin
        next_result = '0;
        case (bus.ALUControl)
            ALU_ADD:  next_result = bus.A + bus.B;
            ALU_SUB:  next_result = bus.A - bus.B;
`ifdef ALU_MUL_EN
            ALU_MUL:  next_result = bus.A * bus.B;
`endif
            ALU_AND:  next_result = bus.A & bus.B;
            ALU_OR:   next_result = bus.A | bus.B;
            ALU_XOR:  next_result = bus.A ^ bus.B;
            ALU_NOR:  next_result = ~(bus.A | bus.B);
            ALU_SLT:  next_result = WIDTH'($signed(bus.A) < $signed(bus.B));
            ALU_SLTU: next_result = WIDTH'(bus.A < bus.B);
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_ROTR:
                      next_result = shift_result_c;
            ALU_LUI:  next_result = {bus.B[15:0], 16'h0000};
            default:  next_result = '0;
        endcase
    end

    // Zero comes from the next-state value so it always tracks the registered result.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            bus.ALUResult <= '0;
            bus.Zero      <= 1'b1;
        end else begin
            bus.ALUResult <= next_result;
            bus.Zero      <= (next_result == '0);
        end
    end

endmodule

// File: tb/tb_alu_32bit.sv
// Self-checking bench for alu_32bit: directed vector table, reset sequences and a random run vs. a reference model.
`timescale 1ns/1ps
module tb_alu_32bit;
    import alu_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    vec_t vecs[$];

    alu_32bit_if bus_if ();

    alu_32bit dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built bit-by-bit / with wide arithmetic from the opcode definitions.
    function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wide;
        logic [31:0] r;
        int          sh;
        sh = int'(a[4:0]);
        r  = '0;
        case (op)
            4'd0: begin wide = 64'(a) + 64'(b); r = wide[31:0]; end
            4'd1: begin wide = 64'h1_0000_0000 + 64'(a) - 64'(b); r = wide[31:0]; end
            4'd2: begin
`ifdef ALU_MUL_EN
                wide = 64'(a) * 64'(b); r = wide[31:0];
`else
                r = '0;
`endif
            end
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: r = ~(a | b);
            4'd7: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd8: r = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'd9:  for (int i = 0; i < 32; i++) r[i] = (i >= sh) ? b[i-sh] : 1'b0;
            4'd10: for (int i = 0; i < 32; i++) r[i] = (i + sh < 32) ? b[i+sh] : 1'b0;
            4'd11: for (int i = 0; i < 32; i++) r[i] = (i + sh < 32) ? b[i+sh] : b[31];
            4'd12: for (int i = 0; i < 32; i++) r[i] = b[(i + sh) % 32];
            4'd13: begin wide = 64'(b[15:0]) * 64'd65536; r = wide[31:0]; end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] exp_r, input logic exp_z);
        n_cmp++;
        if (bus_if.ALUResult !== exp_r || bus_if.Zero !== exp_z) begin
            n_bad++;
            $display("FAIL %s: got result=%08h zero=%0b, expected result=%08h zero=%0b",
                     name, bus_if.ALUResult, bus_if.Zero, exp_r, exp_z);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus_if.ALUControl = op;
        bus_if.A          = a;
        bus_if.B          = b;
    endtask

    function automatic logic [31:0] mul_exp(input logic [31:0] v);
`ifdef ALU_MUL_EN
        return v;
`else
        return (v == v) ? 32'h0 : 32'h0;
`endif
    endfunction

    task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input string name);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b, e;
        n_cmp = 0;
        n_bad = 0;

        add_vec(ALU_ADD,  32'h000003E8, 32'h00000112, 32'h000004FA, "add_small");
        add_vec(ALU_ADD,  32'hFFFF0000, 32'h1000000F, 32'h0FFF000F, "add_carry");
        add_vec(ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, "add_wrap");
        add_vec(ALU_ADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "add_ones");
        add_vec(ALU_SUB,  32'h000003E8, 32'h00000112, 32'h000002D6, "sub_pos");
        add_vec(ALU_SUB,  32'h00000112, 32'h000003E8, 32'hFFFFFD2A, "sub_neg");
        add_vec(ALU_SUB,  32'hFFFF0000, 32'h0000000F, 32'hFFFEFFF1, "sub_borrow");
        add_vec(ALU_SUB,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, "sub_one");
        add_vec(ALU_SUB,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "sub_self");
        add_vec(ALU_MUL,  32'h0000038E, 32'h00000112, mul_exp(32'h0003CDFC), "mul_small");
        add_vec(ALU_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, mul_exp(32'h00000001), "mul_ones");
        add_vec(ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, "and");
        add_vec(ALU_OR,   32'hF0F0F0F0, 32'h0F000001, 32'hFFF0F0F1, "or");
        add_vec(ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, "xor");
        add_vec(ALU_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, "nor_zero");
        add_vec(ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, "slt_neg");
        add_vec(ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, "sltu_big");
        add_vec(ALU_SLL,  32'h00000004, 32'h80000001, 32'h00000010, "sll4");
        add_vec(ALU_SRL,  32'h00000004, 32'h80000001, 32'h08000000, "srl4");
        add_vec(ALU_SRA,  32'h00000004, 32'h80000001, 32'hF8000000, "sra4");
        add_vec(ALU_ROTR, 32'h00000004, 32'h80000001, 32'h18000000, "rotr4");
        add_vec(ALU_ROTR, 32'hFFFFFFE0, 32'h80000001, 32'h80000001, "rotr0_hi_ignored");
        add_vec(ALU_SRA,  32'h0000001F, 32'h80000000, 32'hFFFFFFFF, "sra31");
        add_vec(ALU_SLL,  32'h00000000, 32'h12345678, 32'h12345678, "sll0");
        add_vec(ALU_LUI,  32'h00000000, 32'hABCD1234, 32'h12340000, "lui");
        add_vec(4'b1110,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, "rsv_e");
        add_vec(4'b1111,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "rsv_f");

        // Asynchronous reset asserted between clock edges.
        drive(ALU_ADD, 32'h1, 32'h1);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("reset_async", 32'h0, 1'b1);
        repeat (2) @(posedge clk);
        #1 check("reset_held", 32'h0, 1'b1);

        // Release away from an edge; first capture on the following rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("first_capture", 32'h2, 1'b0);

        // Directed table applied back-to-back, one vector per cycle.
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            @(posedge clk);
            #1 check(vecs[i].name, vecs[i].exp, vecs[i].exp == 32'h0);
        end

        // Mid-stream reset clears a nonzero result without a clock edge.
        drive(ALU_OR, 32'h00F00000, 32'h0000000F);
        @(posedge clk);
        #1 check("pre_reset", 32'h00F0000F, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("reset_midstream", 32'h0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(ALU_SUB, 32'h5, 32'h3);
        @(posedge clk);
        #1 check("post_reset_capture", 32'h2, 1'b0);

        // Randomized back-to-back stream against the reference model.
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if (($urandom & 3) == 0) a = 32'($urandom_range(0, 40));
            if (($urandom & 7) == 0) b = a;
            if (($urandom & 7) == 1) b = 32'hFFFFFFFF;
            drive(op, a, b);
            e = ref_model(op, a, b);
            @(posedge clk);
            #1 check("random", e, e == 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
